// File: rtl/sd_meter_pkg.sv
// Shared definitions for the sigma-delta density meter: FSM state encodings
// and the count-width derivation.
package sd_meter_pkg;

  localparam logic [0:0] ST_PRIME = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  // Count must hold 0..2^win_log2 inclusive, hence one extra bit.
  function automatic int unsigned acc_width(input int unsigned win_log2);
    return win_log2 + 1;
  endfunction

endpackage

// File: rtl/sd_density_ch.sv
// One density channel: window accumulator, last-window sample register and
// hysteresis level flop.
module sd_density_ch
  import sd_meter_pkg::*;
#(
  parameter int unsigned ACC_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic             first,
  input  logic             upd,
  input  logic             sig,
  input  logic [ACC_W-1:0] thr_hi,
  input  logic [ACC_W-1:0] thr_lo,
  output logic [ACC_W-1:0] sample,
  output logic             level
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] count_c;

  assign count_c = acc + ACC_W'(sig);

  // First cycle of a window loads the bit so nothing carries over.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= first ? ACC_W'(sig) : count_c;
    end
  end

  // Set threshold is checked first so it wins when the thresholds overlap.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample <= '0;
      level  <= 1'b0;
    end else if (upd) begin
      sample <= count_c;
      if (count_c >= thr_hi) begin
        level <= 1'b1;
      end else if (count_c <= thr_lo) begin
        level <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sd_density_meter.sv
// Multi-channel sigma-delta bitstream density meter with a shared window
// phase counter, optional discard of the first window, and hysteresis levels.
module sd_density_meter
  import sd_meter_pkg::*;
#(
  parameter int unsigned N_CH     = 1,
  parameter int unsigned WIN_LOG2 = 8,
  parameter int unsigned PRIME    = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           clear,
  input  logic [N_CH-1:0]                sig,
  input  logic [WIN_LOG2:0]              thr_hi,
  input  logic [WIN_LOG2:0]              thr_lo,
  output logic [N_CH*(WIN_LOG2+1)-1:0]   sample,
  output logic                           sample_valid,
  output logic [N_CH-1:0]                level,
  output logic                           priming
);

  localparam int unsigned ACC_W = acc_width(WIN_LOG2);
  localparam logic [0:0]  ST_RESET = (PRIME != 0) ? ST_PRIME : ST_RUN;

  logic [WIN_LOG2-1:0] phase;
  logic [0:0]          state;
  logic [0:0]          next_state;
  logic                close_c;
  logic                upd_c;
  logic                first_c;

  assign first_c = (phase == '0);
  assign close_c = en && !clear && (phase == '1);
  assign upd_c   = close_c && (state == ST_RUN);
  assign priming = (state == ST_PRIME);

  // Shared window phase; clear restarts the window.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= '0;
    end else if (clear) begin
      phase <= '0;
    end else if (en) begin
      phase <= phase + WIN_LOG2'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RESET;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if ((state == ST_PRIME) && close_c) begin
      next_state = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= upd_c;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    sd_density_ch #(
      .ACC_W (ACC_W)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .clear  (clear),
      .first  (first_c),
      .upd    (upd_c),
      .sig    (sig[k]),
      .thr_hi (thr_hi),
      .thr_lo (thr_lo),
      .sample (sample[k*ACC_W +: ACC_W]),
      .level  (level[k])
    );
  end

endmodule

// File: tb/tb_sd_density_meter.sv
// Self-checking bench for sd_density_meter: directed scenarios plus random
// traffic, compared every cycle against a window-sum reference model.
module tb_sd_density_meter;

  localparam int unsigned N_CH     = 2;
  localparam int unsigned WIN_LOG2 = 4;
  localparam int unsigned PRIME    = 1;
  localparam int          W        = 16;
  localparam int unsigned ACC_W    = WIN_LOG2 + 1;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      en;
  logic                      clear;
  logic [N_CH-1:0]           sig;
  logic [ACC_W-1:0]          thr_hi;
  logic [ACC_W-1:0]          thr_lo;
  logic [N_CH*ACC_W-1:0]     sample;
  logic                      sample_valid;
  logic [N_CH-1:0]           level;
  logic                      priming;

  int tests = 0;
  int fails = 0;

  // Reference model: bits seen in the current window, and last published results.
  int m_n;
  int m_cnt    [N_CH];
  int m_sample [N_CH];
  bit m_level  [N_CH];
  bit m_valid;
  bit m_priming;

  sd_density_meter #(
    .N_CH     (N_CH),
    .WIN_LOG2 (WIN_LOG2),
    .PRIME    (PRIME)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .clear        (clear),
    .sig          (sig),
    .thr_hi       (thr_hi),
    .thr_lo       (thr_lo),
    .sample       (sample),
    .sample_valid (sample_valid),
    .level        (level),
    .priming      (priming)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    if (rst) begin
      m_n = 0;
      m_valid = 1'b0;
      m_priming = (PRIME != 0);
      for (int k = 0; k < N_CH; k++) begin
        m_cnt[k] = 0;
        m_sample[k] = 0;
        m_level[k] = 1'b0;
      end
    end else begin
      m_valid = 1'b0;
      if (clear) begin
        m_n = 0;
        for (int k = 0; k < N_CH; k++) m_cnt[k] = 0;
      end else if (en) begin
        for (int k = 0; k < N_CH; k++) m_cnt[k] += int'(sig[k]);
        m_n++;
        if (m_n == W) begin
          if (m_priming) begin
            m_priming = 1'b0;
          end else begin
            m_valid = 1'b1;
            for (int k = 0; k < N_CH; k++) begin
              m_sample[k] = m_cnt[k];
              if (m_cnt[k] >= int'(thr_hi)) m_level[k] = 1'b1;
              else if (m_cnt[k] <= int'(thr_lo)) m_level[k] = 1'b0;
            end
          end
          m_n = 0;
          for (int k = 0; k < N_CH; k++) m_cnt[k] = 0;
        end
      end
    end
  endtask

  task automatic check(input string tag);
    logic [N_CH*ACC_W-1:0] es;
    logic [N_CH-1:0]       el;
    for (int k = 0; k < N_CH; k++) begin
      es[k*ACC_W +: ACC_W] = ACC_W'(m_sample[k]);
      el[k] = m_level[k];
    end
    tests++;
    assert (sample_valid === m_valid) else begin
      fails++;
      $error("FAIL %s sample_valid observed=%0b expected=%0b", tag, sample_valid, m_valid);
    end
    tests++;
    assert (sample === es) else begin
      fails++;
      $error("FAIL %s sample observed=%h expected=%h", tag, sample, es);
    end
    tests++;
    assert (level === el) else begin
      fails++;
      $error("FAIL %s level observed=%b expected=%b", tag, level, el);
    end
    tests++;
    assert (priming === m_priming) else begin
      fails++;
      $error("FAIL %s priming observed=%0b expected=%0b", tag, priming, m_priming);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check(tag);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic run_to_pos(input int pos, input string tag);
    for (int i = 0; i < 4 * W && m_n != pos; i++) step(tag);
    tests++;
    assert (m_n == pos) else begin
      fails++;
      $error("FAIL %s window position observed=%0d expected=%0d", tag, m_n, pos);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clear = 1'b0; sig = '0;
    thr_hi = ACC_W'(12); thr_lo = ACC_W'(4);
    m_n = 0; m_valid = 1'b0; m_priming = 1'b1;
    for (int k = 0; k < N_CH; k++) begin
      m_cnt[k] = 0; m_sample[k] = 0; m_level[k] = 1'b0;
    end
    run(2, "reset");

    // Constant stream: priming window discarded, then ch0=16, ch1=0.
    rst = 1'b0; en = 1'b1; sig = 2'b01;
    run(48, "const");

    // Alternating ch0 gives 8 (level holds), then zero drops level[0].
    for (int i = 0; i < 2 * W; i++) begin
      sig = {1'b0, i[0]};
      step("alternate");
    end
    sig = 2'b00;
    run(W, "zero");

    // Overlapping thresholds with count 13: set threshold takes priority.
    thr_hi = ACC_W'(12); thr_lo = ACC_W'(14);
    run_to_pos(0, "overlap_align");
    for (int i = 0; i < 2 * W; i++) begin
      sig = (m_n < 13) ? 2'b11 : 2'b00;
      step("overlap");
    end
    thr_hi = ACC_W'(12); thr_lo = ACC_W'(4);

    // en stalls mid-window delay the close without changing the count.
    sig = 2'b11;
    run_to_pos(7, "stall_align");
    en = 1'b0;
    run(5, "stall");
    en = 1'b1;
    run(2 * W, "stall_resume");

    // clear at phase 9 restarts the window; no close at the old point.
    run_to_pos(9, "clear_align");
    clear = 1'b1;
    step("clear");
    clear = 1'b0;
    run(2 * W, "after_clear");

    // Reset on the closing cycle of a RUN window, with en and clear also high.
    run_to_pos(W - 1, "rst_align");
    rst = 1'b1; clear = 1'b1;
    step("rst_close");
    rst = 1'b0; clear = 1'b0;
    run(3 * W, "after_rst");

    // Random traffic with occasional stalls, clears, threshold moves and resets.
    for (int i = 0; i < 600; i++) begin
      sig   = N_CH'($urandom);
      en    = ($urandom_range(0, 9) != 0);
      clear = ($urandom_range(0, 49) == 0);
      rst   = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 63) == 0) begin
        thr_hi = ACC_W'($urandom_range(0, W));
        thr_lo = ACC_W'($urandom_range(0, W));
      end
      step("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sd_density_meter.md
SD_DENSITY_METER -- requirements
Module: sd_density_meter

Interface
REQ-001 Parameter N_CH, default 1, number of independent 1-bit sigma-delta channels.
REQ-002 Parameter WIN_LOG2, default 8, window length W = 2^WIN_LOG2 enabled cycles.
REQ-003 Parameter PRIME, default 1, nonzero = discard first window after reset.
REQ-004 Localparam ACC_W = WIN_LOG2+1, count width, holding 0..W inclusive.
REQ-005 clk  input  1  sole clock; all logic on posedge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 en  input  1  cycle qualifier; sig sampled and phase advanced only when high.
REQ-008 clear  input  1  restart current window; partial count discarded.
REQ-009 sig  input  N_CH  digitizer bitstreams, already synchronous to clk.
REQ-010 thr_hi  input  ACC_W  hysteresis set threshold, shared by all channels.
REQ-011 thr_lo  input  ACC_W  hysteresis clear threshold, shared by all channels.
REQ-012 sample  output  N_CH*ACC_W  last completed window count per channel; channel k at bits [k*ACC_W +: ACC_W].
REQ-013 sample_valid  output  1  one-cycle strobe, sample updated.
REQ-014 level  output  N_CH  per-channel hysteresis comparator result.
REQ-015 priming  output  1  high while the discard window runs.

Function
REQ-016 Shared phase counter, WIN_LOG2 bits, increments on each en cycle, wraps W-1 -> 0.
REQ-017 Per-channel accumulator adds sig[k] on each en cycle; at phase 0 it loads sig[k], no carry-over from the prior window.
REQ-018 Window closes on the en edge with phase == W-1; closing count = acc + sig[k], range 0..W, never saturates or wraps.
REQ-019 FSM states PRIME and RUN; rst -> PRIME if PRIME != 0, else RUN; PRIME -> RUN on first window close; RUN holds.
REQ-020 In PRIME the window close updates nothing: no sample, no sample_valid, no level change.
REQ-021 In RUN, at window close: sample <= closing counts, sample_valid <= 1 for exactly the next cycle, level updated same edge (latency 1 cycle from last sample).
REQ-022 Level rule per channel: count >= thr_hi -> 1; else count <= thr_lo -> 0; else hold; thr_hi wins when thresholds overlap.
REQ-023 en low: phase, accumulators, FSM hold; sig ignored; sample_valid 0.
REQ-024 clear high: phase <= 0, accumulators <= 0, FSM state unchanged, no close that cycle even if phase == W-1 and en; clear dominates en.
REQ-025 sample and level hold between closes; thresholds change takes effect at next close only.
REQ-026 priming = (state == PRIME).

Reset
REQ-027 rst forces phase 0, accumulators 0, sample 0, sample_valid 0, level 0, state per REQ-019, in any cycle including a closing one.
REQ-028 rst dominates clear and en; first post-reset valid after 2W en cycles (PRIME=1) or W (PRIME=0).

Structure
REQ-029 Package sd_meter_pkg holds FSM state encodings and ACC_W derivation.
REQ-030 Sub-module sd_density_ch: one accumulator, sample register and hysteresis flop, instantiated N_CH times; phase counter and FSM live in the top.

Verification (N_CH=2, WIN_LOG2=4, W=16, PRIME=1, thr_hi=12, thr_lo=4, en=1 unless stated)
REQ-031 sig={0,1} constant from reset -> no valid for 16 cycles, priming high; valid every 16 cycles after, sample ch0=16, ch1=0; level=2'b01.
REQ-032 sig[0] alternating 1,0 -> ch0 count 8 each window; level[0] holds prior value; then sig[0]=0 -> count 0, level[0] drops.
REQ-033 en low 5 cycles mid-window with sig=all-1 -> sample_valid 5 cycles late, counts still 16.
REQ-034 clear pulse at phase 9 in RUN -> no valid at expected point; next valid 16 en cycles after clear; priming stays low.
REQ-035 rst at phase W-1 of a RUN window -> no valid, all outputs 0, priming high; first valid 32 cycles later.
REQ-036 thr_lo=14 > thr_hi=12, count 13 -> level set to 1 (thr_hi priority).
